// File: rtl/fir_out_requant.sv
// Output re-quantizer for the 15-tap FIR: round-half-up, arithmetic shift and saturate
// a Q2.30 accumulator stream down to Q1.15 over a two-stage back-pressured AXI-Stream pipe.
module fir_out_requant #(
    parameter int IW    = 32,
    parameter int OW    = 16,
    parameter int SHIFT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    input  logic          s_axis_tlast,
    output logic          s_axis_tready,
    output logic [OW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    output logic          m_axis_tlast,
    input  logic          m_axis_tready,
    input  logic          clear,
    output logic [15:0]   sat_count,
    output logic [15:0]   frame_count
);

    localparam logic [IW:0] RND = {{IW{1'b0}}, 1'b1} << (SHIFT - 1);

    logic signed [IW:0] r_a;
    logic               last_a;
    logic               v_a;
    logic               adv_a;
    logic               adv_b;
    logic signed [IW:0] r_next;
    logic signed [IW:0] q_full;
    logic [IW-OW+1:0]   q_hi;
    logic               pos_sat;
    logic               neg_sat;
    logic               sat_a;
    logic [OW-1:0]      q_sat;

    assign adv_b         = !m_axis_tvalid || m_axis_tready;
    assign adv_a         = !v_a || adv_b;
    assign s_axis_tready = reset && adv_a;

    // Sign-extend one bit so the rounding constant can never overflow the add.
    assign r_next = $signed({s_axis_tdata[IW-1], s_axis_tdata}) + $signed(RND);

    // The shifted value fits OW bits only when everything from bit OW-1 up is a sign copy.
    assign q_full  = r_a >>> SHIFT;
    assign q_hi    = q_full[IW:OW-1];
    assign pos_sat = !q_full[IW] && (|q_hi);
    assign neg_sat =  q_full[IW] && !(&q_hi);
    assign sat_a   = pos_sat || neg_sat;

    always_comb begin
        q_sat = q_full[OW-1:0];
        if (pos_sat)
            q_sat = {1'b0, {(OW-1){1'b1}}};
        else if (neg_sat)
            q_sat = {1'b1, {(OW-1){1'b0}}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_a    <= 1'b0;
            r_a    <= '0;
            last_a <= 1'b0;
        end else if (adv_a) begin
            v_a    <= s_axis_tvalid;
            r_a    <= r_next;
            last_a <= s_axis_tlast;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (adv_b) begin
            m_axis_tvalid <= v_a;
            m_axis_tdata  <= q_sat;
            m_axis_tlast  <= last_a;
        end
    end

    // Clear takes priority over any increment landing in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_count   <= '0;
            frame_count <= '0;
        end else if (clear) begin
            sat_count   <= '0;
            frame_count <= '0;
        end else begin
            if (adv_b && v_a && sat_a && (sat_count != 16'hFFFF))
                sat_count <= sat_count + 16'd1;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                frame_count <= frame_count + 16'd1;
        end
    end

endmodule
